// File: rtl/axis_packet_source_pkg.sv
// Shared types and beat-data encoding for the NoC AXI-Stream packet source and
// for the sink-side checker that predicts every beat.
package axis_packet_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } src_state_t;

  localparam int IDX_W = 16;

  function automatic logic [31:0] mk_src_data(input logic [IDX_W-1:0] pkt_idx,
                                              input logic [IDX_W-1:0] beat_idx);
    return {pkt_idx, beat_idx};
  endfunction

endpackage

// File: rtl/axis_packet_source_if.sv
// AXI-Stream link between a packet source and a router ingress / sink.
interface axis_packet_source_if #(
  parameter int TDATAW = 32,
  parameter int TDESTW = 4,
  parameter int TIDW   = 2
);
  logic              tvalid;
  logic              tready;
  logic [TDATAW-1:0] tdata;
  logic              tlast;
  logic [TIDW-1:0]   tid;
  logic [TDESTW-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_packet_source.sv
// AXI-Stream traffic generator: on START emits NUM_PKTS packets of PKT_LEN beats
// with deterministic data/TID/TDEST, then raises a sticky DONE.
module axis_packet_source
  import axis_packet_source_pkg::*;
#(
  parameter int TDATAW     = 32,
  parameter int TDESTW     = 4,
  parameter int TIDW       = 2,
  parameter int PKT_LEN    = 4,
  parameter int NUM_DESTS  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [15:0]         NUM_PKTS,
  input  logic [TDESTW-1:0]   DEST_BASE,
  output logic                BUSY,
  output logic                DONE,
  axis_packet_source_if.master axis
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0]    LAST_BEAT = IDX_W'(PKT_LEN - 1);
  localparam logic [TDESTW-1:0]   LAST_DEST = TDESTW'(NUM_DESTS - 1);
  localparam logic [GAP_W-1:0]    LAST_GAP  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TDESTW+15:0]  DEST_MOD  = (TDESTW+16)'(NUM_DESTS);
  localparam logic                ONE_BEAT  = (PKT_LEN == 1);

  src_state_t         state, state_n;
  logic [IDX_W-1:0]   beat_idx, beat_n;
  logic [IDX_W-1:0]   pkt_idx, pkt_n;
  logic [IDX_W-1:0]   num_q, num_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;

  logic               valid_n, last_n, done_n, busy_n;
  logic [TDATAW-1:0]  data_n;
  logic [TIDW-1:0]    tid_n;
  logic [TDESTW-1:0]  dest_n;

  logic               xfer;
  logic [IDX_W-1:0]   beat_inc, pkt_inc;
  logic [TDESTW-1:0]  dest_inc;
  logic [TDESTW+15:0] base_mod;

  assign xfer     = axis.tvalid & axis.tready;
  assign beat_inc = beat_idx + 16'd1;
  assign pkt_inc  = pkt_idx + 16'd1;
  assign dest_inc = (axis.tdest == LAST_DEST) ? '0 : axis.tdest + 1'b1;
  assign base_mod = (TDESTW+16)'(DEST_BASE) % DEST_MOD;

  always_comb begin
    state_n = state;
    beat_n  = beat_idx;
    pkt_n   = pkt_idx;
    num_n   = num_q;
    gap_n   = gap_cnt;
    valid_n = axis.tvalid;
    data_n  = axis.tdata;
    last_n  = axis.tlast;
    tid_n   = axis.tid;
    dest_n  = axis.tdest;
    done_n  = DONE;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          num_n  = NUM_PKTS;
          beat_n = '0;
          pkt_n  = '0;
          gap_n  = '0;
          done_n = 1'b0;
          if (NUM_PKTS == 16'd0) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_SEND;
            valid_n = 1'b1;
            data_n  = TDATAW'(mk_src_data(16'd0, 16'd0));
            last_n  = ONE_BEAT;
            tid_n   = '0;
            dest_n  = base_mod[TDESTW-1:0];
          end
        end
      end

      ST_SEND: begin
        if (xfer) begin
          if (!axis.tlast) begin
            beat_n = beat_inc;
            data_n = TDATAW'(mk_src_data(pkt_idx, beat_inc));
            last_n = (beat_inc == LAST_BEAT);
          end else begin
            // Next packet's first beat is staged now and held through GAP,
            // so leaving GAP only has to raise TVALID.
            beat_n = '0;
            pkt_n  = pkt_inc;
            data_n = TDATAW'(mk_src_data(pkt_inc, 16'd0));
            last_n = ONE_BEAT;
            tid_n  = pkt_inc[TIDW-1:0];
            dest_n = dest_inc;
            if (pkt_inc == num_q) begin
              state_n = ST_DONE;
              valid_n = 1'b0;
              done_n  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_n = ST_GAP;
              valid_n = 1'b0;
              gap_n   = '0;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_n = ST_SEND;
          valid_n = 1'b1;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n == ST_SEND) || (state_n == ST_GAP);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      beat_idx    <= '0;
      pkt_idx     <= '0;
      num_q       <= '0;
      gap_cnt     <= '0;
      axis.tvalid <= 1'b0;
      axis.tdata  <= '0;
      axis.tlast  <= 1'b0;
      axis.tid    <= '0;
      axis.tdest  <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state       <= state_n;
      beat_idx    <= beat_n;
      pkt_idx     <= pkt_n;
      num_q       <= num_n;
      gap_cnt     <= gap_n;
      axis.tvalid <= valid_n;
      axis.tdata  <= data_n;
      axis.tlast  <= last_n;
      axis.tid    <= tid_n;
      axis.tdest  <= dest_n;
      BUSY        <= busy_n;
      DONE        <= done_n;
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed bench for axis_packet_source with default parameters
// (32-bit data, PKT_LEN 4, NUM_DESTS 4, GAP_CYCLES 2).
module tb_axis_packet_source;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [15:0] NUM_PKTS;
  logic [3:0]  DEST_BASE;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  axis_packet_source_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) axis ();

  axis_packet_source #(
    .TDATAW(32), .TDESTW(4), .TIDW(2), .PKT_LEN(4), .NUM_DESTS(4), .GAP_CYCLES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .NUM_PKTS(NUM_PKTS),
    .DEST_BASE(DEST_BASE), .BUSY(BUSY), .DONE(DONE), .axis(axis)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    checks++;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: tvalid=%b tlast=%b busy=%b done=%b, want all 0",
               axis.tvalid, axis.tlast, BUSY, DONE);
    end
    checks++;
    if (axis.tdata !== 32'h0 || axis.tid !== 2'd0 || axis.tdest !== 4'd0) begin
      errors++;
      $display("FAIL reset_bus: tdata=%h tid=%0d tdest=%0d, want 0/0/0",
               axis.tdata, axis.tid, axis.tdest);
    end
  endtask

  task automatic test_basic();
    int k = 0, last_cyc = 0;
    logic [31:0] exp;
    axis.tready = 1'b1;
    @(negedge CLK); START = 1'b1; NUM_PKTS = 16'd2; DEST_BASE = 4'd1;
    @(negedge CLK); START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || axis.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: busy=%b tvalid=%b, want 1/1", BUSY, axis.tvalid);
    end
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      if (axis.tvalid === 1'b1) begin
        exp = ((k / 4) << 16) | (k % 4);
        checks++;
        if (axis.tdata !== exp || axis.tlast !== (k % 4 == 3)) begin
          errors++;
          $display("FAIL basic_beat%0d: tdata=%h tlast=%b, want %h/%b",
                   k, axis.tdata, axis.tlast, exp, (k % 4 == 3));
        end
        checks++;
        if (axis.tdest !== 4'(1 + k / 4) || axis.tid !== 2'(k / 4)) begin
          errors++;
          $display("FAIL basic_route%0d: tdest=%0d tid=%0d, want %0d/%0d",
                   k, axis.tdest, axis.tid, 1 + k / 4, k / 4);
        end
        if (k == 4) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL basic_gap: spacing=%0d, want 3 (2 idle cycles)", cyc - last_cyc);
          end
        end
        if (k > 0 && k != 4) begin
          checks++;
          if (cyc - last_cyc != 1) begin
            errors++;
            $display("FAIL basic_bubble%0d: spacing=%0d, want 1", k, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        k++;
      end
      @(negedge CLK);
    end
    checks++;
    if (k != 8 || DONE !== 1'b1 || axis.tvalid !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: beats=%0d done=%b tvalid=%b busy=%b, want 8/1/0/0",
               k, DONE, axis.tvalid, BUSY);
    end
  endtask

  task automatic test_backpressure();
    int k = 0, stalls = 0;
    bit stalled = 0;
    logic [31:0] sd;
    logic sl;
    @(negedge CLK); START = 1'b1; NUM_PKTS = 16'd1; DEST_BASE = 4'd0;
    @(negedge CLK); START = 1'b0;
    for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
      if (stalled) begin
        checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== sd || axis.tlast !== sl) begin
          errors++;
          $display("FAIL bp_stable: tvalid=%b tdata=%h tlast=%b, want 1/%h/%b",
                   axis.tvalid, axis.tdata, axis.tlast, sd, sl);
        end
      end
      axis.tready = (cyc % 2 == 0);
      if (axis.tvalid === 1'b1 && axis.tready) begin
        checks++;
        if (axis.tdata !== 32'(k) || axis.tlast !== (k == 3)) begin
          errors++;
          $display("FAIL bp_beat%0d: tdata=%h tlast=%b, want %h/%b",
                   k, axis.tdata, axis.tlast, 32'(k), (k == 3));
        end
        k++;
        stalled = 0;
      end else if (axis.tvalid === 1'b1) begin
        stalled = 1; sd = axis.tdata; sl = axis.tlast; stalls++;
      end
      @(negedge CLK);
    end
    checks++;
    if (k != 4 || stalls != 3 || DONE !== 1'b1 || axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_total: transfers=%0d stalls=%0d done=%b tvalid=%b, want 4/3/1/0",
               k, stalls, DONE, axis.tvalid);
    end
    axis.tready = 1'b1;
  endtask

  task automatic test_zero_pkts();
    bit seen_valid = 0;
    RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK); START = 1'b1; NUM_PKTS = 16'd0; DEST_BASE = 4'd2;
    @(negedge CLK); START = 1'b0;
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b, want 1/0", DONE, BUSY);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (axis.tvalid !== 1'b0) seen_valid = 1;
      @(negedge CLK);
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("FAIL zero_novalid: tvalid seen=1, want 0");
    end
  endtask

  task automatic test_dest_wrap();
    int k = 0;
    logic [3:0] exp_dest[5] = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
    logic [1:0] exp_tid[5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] last_data = '0;
    axis.tready = 1'b1;
    @(negedge CLK); START = 1'b1; NUM_PKTS = 16'd5; DEST_BASE = 4'd3;
    @(negedge CLK); START = 1'b0;
    for (int cyc = 0; cyc < 100 && k < 20; cyc++) begin
      if (axis.tvalid === 1'b1) begin
        if (k % 4 == 0) begin
          checks++;
          if (axis.tdest !== exp_dest[k/4] || axis.tid !== exp_tid[k/4]) begin
            errors++;
            $display("FAIL wrap_pkt%0d: tdest=%0d tid=%0d, want %0d/%0d",
                     k / 4, axis.tdest, axis.tid, exp_dest[k/4], exp_tid[k/4]);
          end
        end
        last_data = axis.tdata;
        k++;
      end
      @(negedge CLK);
    end
    checks++;
    if (k != 20 || last_data !== 32'h0004_0003 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL wrap_total: beats=%0d last=%h done=%b, want 20/00040003/1",
               k, last_data, DONE);
    end
  endtask

  task automatic test_start_ignored();
    int k = 0;
    bit bad_dest = 0;
    axis.tready = 1'b1;
    @(negedge CLK); START = 1'b1; NUM_PKTS = 16'd3; DEST_BASE = 4'd0;
    @(negedge CLK); START = 1'b0;
    for (int cyc = 0; cyc < 60 && DONE !== 1'b1; cyc++) begin
      START = (cyc == 2 || cyc == 5);
      NUM_PKTS = 16'd9; DEST_BASE = 4'd2;
      if (axis.tvalid === 1'b1) begin
        if (axis.tdest !== 4'(k / 4) || axis.tdata !== 32'(((k / 4) << 16) | (k % 4))) bad_dest = 1;
        k++;
      end
      @(negedge CLK);
    end
    START = 1'b0;
    @(negedge CLK);
    checks++;
    if (k != 12 || bad_dest || DONE !== 1'b1 || axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: beats=%0d bad=%0d done=%b tvalid=%b, want 12/0/1/0",
               k, bad_dest, DONE, axis.tvalid);
    end
    START = 1'b1; NUM_PKTS = 16'd1; DEST_BASE = 4'd2;
    @(negedge CLK); START = 1'b0;
    checks++;
    if (DONE !== 1'b0 || axis.tvalid !== 1'b1 || axis.tdata !== 32'h0 ||
        axis.tdest !== 4'd2 || axis.tid !== 2'd0) begin
      errors++;
      $display("FAIL restart: done=%b tvalid=%b tdata=%h tdest=%0d tid=%0d, want 0/1/0/2/0",
               DONE, axis.tvalid, axis.tdata, axis.tdest, axis.tid);
    end
    for (int cyc = 0; cyc < 20 && DONE !== 1'b1; cyc++) @(negedge CLK);
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: done=%b, want 1", DONE);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0, seen_valid = 0;
    axis.tready = 1'b1;
    @(negedge CLK); START = 1'b1; NUM_PKTS = 16'd1; DEST_BASE = 4'd0;
    @(negedge CLK); START = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      if (axis.tvalid === 1'b1 && axis.tdata === 32'd2) begin
        found = 1;
        axis.tready = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
    @(negedge CLK);
    checks++;
    if (!found || axis.tvalid !== 1'b1 || axis.tdata !== 32'd2) begin
      errors++;
      $display("FAIL arst_setup: found=%0d tvalid=%b tdata=%h, want 1/1/2",
               found, axis.tvalid, axis.tdata);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (axis.tvalid !== 1'b0 || BUSY !== 1'b0 || axis.tdata !== 32'h0) begin
      errors++;
      $display("FAIL arst_drop: tvalid=%b busy=%b tdata=%h, want 0/0/0",
               axis.tvalid, BUSY, axis.tdata);
    end
    @(negedge CLK); RST_N = 1'b1; axis.tready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge CLK);
      if (axis.tvalid !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) seen_valid = 1;
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("FAIL arst_idle: activity seen after reset release, want none");
    end
    START = 1'b1; NUM_PKTS = 16'd1; DEST_BASE = 4'd0;
    @(negedge CLK); START = 1'b0;
    checks++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h0 || axis.tlast !== 1'b0) begin
      errors++;
      $display("FAIL arst_restart: tvalid=%b tdata=%h tlast=%b, want 1/0/0",
               axis.tvalid, axis.tdata, axis.tlast);
    end
    for (int cyc = 0; cyc < 20 && DONE !== 1'b1; cyc++) @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; NUM_PKTS = '0; DEST_BASE = '0; axis.tready = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset();
    RST_N = 1'b1;
    test_basic();
    test_backpressure();
    test_zero_pkts();
    test_dest_wrap();
    test_start_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
